forwarding_hazard_unit: RTL and testbench

Parametrised forwarding and hazard block for the ARM pipeline. It compares every ID-stage source register against the EXE, MEM and WB destinations and registers the resulting forwarding selects into the ID/EXE boundary, so they are valid in EXE on the next cycle. It also tracks a one-cycle "retire" slot for the just-written register, detects load-use and no-forwarding RAW hazards to generate a stall, and keeps a saturating hazard-cycle counter.

---
 rtl/forwarding_hazard_unit.sv | 128 ++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and hazard unit: compares ID-stage sources against EXE/MEM/WB destinations,
// registers per-source forwarding selects into ID/EXE and raises a stall on RAW hazards.
module forwarding_hazard_unit #(
   parameter int ADDR_LEN = 4,
   parameter int NUM_SRC  = 3,
   parameter int PC_REG   = 15,
   parameter int CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        forwarding_enable,
   input  logic [NUM_SRC*ADDR_LEN-1:0] src_addr,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [ADDR_LEN-1:0]         exe_dest,
   input  logic [ADDR_LEN-1:0]         mem_dest,
   input  logic [ADDR_LEN-1:0]         wb_dest,
   input  logic                        exe_wb_en,
   input  logic                        mem_wb_en,
   input  logic                        wb_wb_en,
   input  logic                        exe_mem_r_en,
   input  logic                        pipe_freeze,
   input  logic                        flush,
   output logic [2*NUM_SRC-1:0]        src_select,
   output logic                        ret_load,
   output logic                        ret_valid,
   output logic [ADDR_LEN-1:0]         ret_dest,
   output logic                        hazard_stall,
   output logic [CNT_W-1:0]            hazard_count
);

   localparam logic [ADDR_LEN-1:0] PC_ADDR  = ADDR_LEN'(PC_REG);
   localparam logic [1:0]          SEL_NONE = 2'd0;
   localparam logic [1:0]          SEL_MEM  = 2'd1;
   localparam logic [1:0]          SEL_WB   = 2'd2;
   localparam logic [1:0]          SEL_RET  = 2'd3;
   localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

   // The PC is produced outside the register file, so it is never a forwarding or stall candidate.
   function automatic logic src_match(input logic                v,
                                      input logic                en,
                                      input logic [ADDR_LEN-1:0] a,
                                      input logic [ADDR_LEN-1:0] d);
      return v & en & (a == d) & (a != PC_ADDR);
   endfunction

   logic [NUM_SRC-1:0]    exe_hit_s;
   logic [NUM_SRC-1:0]    mem_hit_s;
   logic [NUM_SRC-1:0]    wb_hit_s;
   logic [2*NUM_SRC-1:0]  next_select_s;
   logic                  stall_raw_s;
   logic [2*NUM_SRC-1:0]  src_select_r;
   logic [CNT_W-1:0]      hazard_count_r;
   logic                  ret_valid_r;
   logic [ADDR_LEN-1:0]   ret_dest_r;

   // Per-source hit detection and youngest-first select encoding.
   always_comb begin
      exe_hit_s     = '0;
      mem_hit_s     = '0;
      wb_hit_s      = '0;
      next_select_s = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         exe_hit_s[i] = src_match(src_valid[i], exe_wb_en, src_addr[i*ADDR_LEN +: ADDR_LEN], exe_dest);
         mem_hit_s[i] = src_match(src_valid[i], mem_wb_en, src_addr[i*ADDR_LEN +: ADDR_LEN], mem_dest);
         wb_hit_s[i]  = src_match(src_valid[i], wb_wb_en,  src_addr[i*ADDR_LEN +: ADDR_LEN], wb_dest);
         if (!forwarding_enable) begin
            next_select_s[2*i +: 2] = SEL_NONE;
         end else if (exe_hit_s[i]) begin
            next_select_s[2*i +: 2] = SEL_MEM;
         end else if (mem_hit_s[i]) begin
            next_select_s[2*i +: 2] = SEL_WB;
         end else if (wb_hit_s[i]) begin
            next_select_s[2*i +: 2] = SEL_RET;
         end else begin
            next_select_s[2*i +: 2] = SEL_NONE;
         end
      end
   end

   // Stall request and retire-latch strobe; both are held low while reset is asserted.
   always_comb begin
      stall_raw_s = 1'b0;
      if (forwarding_enable) begin
         stall_raw_s = exe_mem_r_en & (|exe_hit_s);
      end else begin
         stall_raw_s = (|exe_hit_s) | (|mem_hit_s) | (|wb_hit_s);
      end
      hazard_stall = rst & ~pipe_freeze & ~flush & stall_raw_s;
      ret_load     = rst & wb_wb_en & ~pipe_freeze;
   end

   // ID/EXE select register, retire slot and saturating stall counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_select_r   <= '0;
         hazard_count_r <= '0;
         ret_valid_r    <= 1'b0;
         ret_dest_r     <= '0;
      end else if (flush) begin
         src_select_r   <= '0;
         ret_valid_r    <= 1'b0;
      end else if (pipe_freeze) begin
         src_select_r   <= src_select_r;
         hazard_count_r <= hazard_count_r;
         ret_valid_r    <= ret_valid_r;
         ret_dest_r     <= ret_dest_r;
      end else begin
         ret_valid_r <= wb_wb_en & (wb_dest != PC_ADDR);
         ret_dest_r  <= wb_dest;
         if (hazard_stall) begin
            src_select_r <= '0;
            if (hazard_count_r != CNT_MAX) begin
               hazard_count_r <= hazard_count_r + CNT_W'(1);
            end else begin
               hazard_count_r <= hazard_count_r;
            end
         end else begin
            src_select_r <= next_select_s;
         end
      end
   end

   assign src_select   = src_select_r;
   assign hazard_count = hazard_count_r;
   assign ret_valid    = ret_valid_r;
   assign ret_dest     = ret_dest_r;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit: directed plan cases then random traffic,
// expected responses come from a per-cycle behavioural model of the pipeline rules.
module tb_forwarding_hazard_unit;

   localparam int AL = 4;
   localparam int NS = 3;
   localparam int CW = 2;
   localparam int PC = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          forwarding_enable;
   logic [NS*AL-1:0] src_addr;
   logic [NS-1:0] src_valid;
   logic [AL-1:0] exe_dest, mem_dest, wb_dest;
   logic          exe_wb_en, mem_wb_en, wb_wb_en, exe_mem_r_en, pipe_freeze, flush;
   logic [2*NS-1:0] src_select;
   logic          ret_load, ret_valid, hazard_stall;
   logic [AL-1:0] ret_dest;
   logic [CW-1:0] hazard_count;

   forwarding_hazard_unit #(.ADDR_LEN(AL), .NUM_SRC(NS), .PC_REG(PC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .forwarding_enable(forwarding_enable),
      .src_addr(src_addr), .src_valid(src_valid),
      .exe_dest(exe_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
      .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .pipe_freeze(pipe_freeze), .flush(flush),
      .src_select(src_select), .ret_load(ret_load), .ret_valid(ret_valid),
      .ret_dest(ret_dest), .hazard_stall(hazard_stall), .hazard_count(hazard_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] stall, rload;
      logic [31:0] cur_sel, cur_cnt, cur_rv, cur_rd;
      logic [31:0] nxt_sel, nxt_cnt, nxt_rv, nxt_rd;
   } txn_t;

   txn_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // reference state: per-source select, counter, retire slot
   int m_sel[NS];
   int m_cnt = 0;
   int m_rv  = 0;
   int m_rd  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_sel();
      logic [31:0] p = 32'd0;
      for (int s = 0; s < NS; s++) p = p | (32'(m_sel[s]) << (2 * s));
      return p;
   endfunction

   // Evaluate one cycle of the rules against the currently driven inputs and queue the expectation.
   task automatic issue();
      txn_t t;
      int   dst[3];
      int   en[3];
      int   nxt[NS];
      bit   hit_any = 0;
      bit   hit_exe = 0;
      bit   stall;
      dst[0] = int'(exe_dest); dst[1] = int'(mem_dest); dst[2] = int'(wb_dest);
      en[0]  = int'(exe_wb_en); en[1] = int'(mem_wb_en); en[2] = int'(wb_wb_en);
      if (!rst) begin
         for (int s = 0; s < NS; s++) m_sel[s] = 0;
         m_cnt = 0; m_rv = 0; m_rd = 0;
      end
      t.cur_sel = pack_sel();
      t.cur_cnt = 32'(m_cnt);
      t.cur_rv  = 32'(m_rv);
      t.cur_rd  = 32'(m_rd);
      for (int s = 0; s < NS; s++) begin
         int a = int'(src_addr[s*AL +: AL]);
         nxt[s] = 0;
         // stage 0 = EXE (youngest) ... 2 = WB; the first stage that matches decides
         for (int st = 0; st < 3; st++) begin
            if (src_valid[s] && en[st] != 0 && a == dst[st] && a != PC) begin
               hit_any = 1;
               if (st == 0) hit_exe = 1;
               if (nxt[s] == 0) nxt[s] = st + 1;
            end
         end
         if (!forwarding_enable) nxt[s] = 0;
      end
      stall   = rst && !pipe_freeze && !flush &&
                (forwarding_enable ? (exe_mem_r_en && hit_exe) : hit_any);
      t.stall = 32'(stall);
      t.rload = 32'(rst && wb_wb_en && !pipe_freeze);
      if (!rst) begin
         // state stays cleared
      end else if (flush) begin
         for (int s = 0; s < NS; s++) m_sel[s] = 0;
         m_rv = 0;
      end else if (!pipe_freeze) begin
         m_rv = (wb_wb_en && int'(wb_dest) != PC) ? 1 : 0;
         m_rd = int'(wb_dest);
         if (stall) begin
            for (int s = 0; s < NS; s++) m_sel[s] = 0;
            if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
         end else begin
            for (int s = 0; s < NS; s++) m_sel[s] = nxt[s];
         end
      end
      t.nxt_sel = pack_sel();
      t.nxt_cnt = 32'(m_cnt);
      t.nxt_rv  = 32'(m_rv);
      t.nxt_rd  = 32'(m_rd);
      sb.push_back(t);
   endtask

   task automatic clear_inputs();
      rst = 1'b1; forwarding_enable = 1'b1;
      src_addr = '0; src_valid = '0;
      exe_dest = '0; mem_dest = '0; wb_dest = '0;
      exe_wb_en = 1'b0; mem_wb_en = 1'b0; wb_wb_en = 1'b0;
      exe_mem_r_en = 1'b0; pipe_freeze = 1'b0; flush = 1'b0;
   endtask

   task automatic set_src(input int i, input int a);
      src_addr[i*AL +: AL] = AL'(a);
      src_valid[i] = 1'b1;
   endtask

   task automatic load_use();
      clear_inputs(); set_src(1, 5);
      exe_dest = 4'd5; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
   endtask

   task automatic rand_addr(output logic [AL-1:0] a);
      int r = $urandom_range(0, 4);
      a = (r == 4) ? AL'(PC) : AL'(r);
   endtask

   // Monitor: combinational outputs and pre-edge state mid-cycle, registered state after the edge.
   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            t = sb[0];
            check("hazard_stall", 32'(hazard_stall), t.stall);
            check("ret_load", 32'(ret_load), t.rload);
            check("src_select_pre", 32'(src_select), t.cur_sel);
            check("hazard_count_pre", 32'(hazard_count), t.cur_cnt);
            check("ret_valid_pre", 32'(ret_valid), t.cur_rv);
            check("ret_dest_pre", 32'(ret_dest), t.cur_rd);
            @(posedge clk);
            #1;
            check("src_select", 32'(src_select), t.nxt_sel);
            check("hazard_count", 32'(hazard_count), t.nxt_cnt);
            check("ret_valid", 32'(ret_valid), t.nxt_rv);
            check("ret_dest", 32'(ret_dest), t.nxt_rd);
            void'(sb.pop_front());
         end
      end
   end

   // Stimulus: directed plan cases, then randomized traffic.
   initial begin
      for (int s = 0; s < NS; s++) m_sel[s] = 0;
      clear_inputs();
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk); clear_inputs(); rst = 1'b0; issue();
      end
      @(negedge clk); clear_inputs(); set_src(0, 3); exe_dest = 4'd3; exe_wb_en = 1'b1; issue();
      @(negedge clk); load_use(); issue();
      @(negedge clk); load_use(); pipe_freeze = 1'b1; issue();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); clear_inputs(); set_src(0, 2);
         exe_dest = 4'd2; mem_dest = 4'd2; wb_dest = 4'd2;
         exe_wb_en = (k < 1); mem_wb_en = (k < 2); wb_wb_en = 1'b1;
         issue();
      end
      @(negedge clk); clear_inputs(); set_src(0, PC);
      exe_dest = 4'd15; mem_dest = 4'd15; wb_dest = 4'd15;
      exe_wb_en = 1'b1; mem_wb_en = 1'b1; wb_wb_en = 1'b1; exe_mem_r_en = 1'b1;
      issue();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); clear_inputs(); forwarding_enable = 1'b0;
         mem_dest = 4'd7; mem_wb_en = 1'b1; set_src(2, 7); flush = (k == 1);
         issue();
      end
      repeat (5) begin
         @(negedge clk); load_use(); issue();
      end
      @(negedge clk); load_use(); rst = 1'b0; issue();
      @(negedge clk); load_use(); issue();
      repeat (400) begin
         @(negedge clk);
         clear_inputs();
         for (int s = 0; s < NS; s++) begin
            logic [AL-1:0] a;
            rand_addr(a);
            src_addr[s*AL +: AL] = a;
            src_valid[s] = ($urandom_range(0, 3) != 0);
         end
         rand_addr(exe_dest); rand_addr(mem_dest); rand_addr(wb_dest);
         exe_wb_en = ($urandom_range(0, 3) != 0);
         mem_wb_en = ($urandom_range(0, 3) != 0);
         wb_wb_en = ($urandom_range(0, 3) != 0);
         exe_mem_r_en = ($urandom_range(0, 2) == 0);
         pipe_freeze = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 7) == 0);
         forwarding_enable = ($urandom_range(0, 4) != 0);
         rst = ($urandom_range(0, 39) != 0);
         issue();
      end
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      #3;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
